// File: rtl/core_sequencer_if.sv
// Instruction and data memory handshake bundle between the core sequencer and its memories.
interface core_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;
    logic            dmem_req;
    logic            dmem_ready;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ready,
        input  imem_rdata,
        output dmem_req,
        input  dmem_ready
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ready,
        output imem_rdata,
        input  dmem_req,
        output dmem_ready
    );
endinterface

// File: rtl/core_sequencer.sv
// Multi-cycle control FSM sequencing fetch/decode/execute/mem/writeback with run, single-step
// and halt control, misaligned-target trapping and a retired-instruction counter.
module core_sequencer #(
    parameter int unsigned      XLEN         = 32,
    parameter logic [XLEN-1:0]  RESET_VECTOR = '0,
    parameter int unsigned      CNT_W        = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              step_req,
    input  logic              halt_req,
    core_sequencer_if.master  mem,
    output logic [XLEN-1:0]   instr,
    input  logic              needs_mem,
    input  logic              wb_en_dec,
    input  logic [1:0]        pc_jmp,
    input  logic              branch_taken,
    input  logic [XLEN-1:0]   imm,
    input  logic [XLEN-1:0]   jalr_target,
    output logic [XLEN-1:0]   pc,
    output logic [XLEN-1:0]   link_addr,
    output logic              rf_we,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  retired,
    output logic              halted,
    output logic              misalign
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_DECODE    = 3'd2,
        S_EXECUTE   = 3'd3,
        S_MEM       = 3'd4,
        S_WRITEBACK = 3'd5,
        S_HALT      = 3'd6
    } state_e;

    localparam logic [XLEN-1:0] NOP_INSTR = XLEN'(32'h0000_0013);

    state_e           state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0] retired_q, retired_d;
    logic             misalign_q, misalign_d;
    logic             step_mode_q, step_mode_d;
    logic             step_from_halt_q, step_from_halt_d;
    logic             pending_halt_q, pending_halt_d;

    logic [XLEN-1:0]  pc_plus4;
    logic [XLEN-1:0]  pc_plus_imm;
    logic [XLEN-1:0]  target;
    logic             target_misaligned;
    logic             rf_we_d;

    assign pc_plus4    = pc_q + XLEN'(4);
    assign pc_plus_imm = pc_q + imm;

    always_comb begin
        target = pc_plus4;
        unique case (pc_jmp)
            2'd0: target = pc_plus4;
            2'd1: target = branch_taken ? pc_plus_imm : pc_plus4;
            2'd2: target = pc_plus_imm;
            2'd3: target = {jalr_target[XLEN-1:1], 1'b0};
            default: target = pc_plus4;
        endcase
    end

    assign target_misaligned = |target[1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q          <= S_IDLE;
            pc_q             <= RESET_VECTOR;
            instr_q          <= NOP_INSTR;
            retired_q        <= '0;
            misalign_q       <= 1'b0;
            step_mode_q      <= 1'b0;
            step_from_halt_q <= 1'b0;
            pending_halt_q   <= 1'b0;
        end else begin
            state_q          <= state_d;
            pc_q             <= pc_d;
            instr_q          <= instr_d;
            retired_q        <= retired_d;
            misalign_q       <= misalign_d;
            step_mode_q      <= step_mode_d;
            step_from_halt_q <= step_from_halt_d;
            pending_halt_q   <= pending_halt_d;
        end
    end

    always_comb begin
        state_d          = state_q;
        pc_d             = pc_q;
        instr_d          = instr_q;
        retired_d        = retired_q;
        misalign_d       = misalign_q;
        step_mode_d      = step_mode_q;
        step_from_halt_d = step_from_halt_q;
        pending_halt_d   = pending_halt_q;
        rf_we_d          = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (halt_req) begin
                    state_d = S_HALT;
                end else if (step_req) begin
                    state_d          = S_FETCH;
                    step_mode_d      = 1'b1;
                    step_from_halt_d = 1'b0;
                end else if (enable) begin
                    state_d          = S_FETCH;
                    step_mode_d      = 1'b0;
                    step_from_halt_d = 1'b0;
                end
            end
            S_FETCH: begin
                if (halt_req) pending_halt_d = 1'b1;
                if (mem.imem_ready) begin
                    instr_d = mem.imem_rdata;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                if (halt_req) pending_halt_d = 1'b1;
                state_d = S_EXECUTE;
            end
            S_EXECUTE: begin
                if (halt_req) pending_halt_d = 1'b1;
                state_d = needs_mem ? S_MEM : S_WRITEBACK;
            end
            S_MEM: begin
                if (halt_req) pending_halt_d = 1'b1;
                if (mem.dmem_ready) state_d = S_WRITEBACK;
            end
            S_WRITEBACK: begin
                if (target_misaligned) begin
                    misalign_d = 1'b1;
                    state_d    = S_HALT;
                end else begin
                    pc_d      = target;
                    rf_we_d   = wb_en_dec;
                    retired_d = retired_q + CNT_W'(1);
                    if (halt_req || pending_halt_q) begin
                        state_d = S_HALT;
                    end else if (step_mode_q) begin
                        state_d = step_from_halt_q ? S_HALT : S_IDLE;
                    end else if (enable) begin
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_HALT: begin
                if (step_req) begin
                    state_d          = S_FETCH;
                    step_mode_d      = 1'b1;
                    step_from_halt_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A halt request latched mid-instruction is consumed by whichever path reaches HALT.
        if (state_d == S_HALT) pending_halt_d = 1'b0;
    end

    assign mem.imem_req  = (state_q == S_FETCH);
    assign mem.imem_addr = pc_q;
    assign mem.dmem_req  = (state_q == S_MEM);

    assign instr     = instr_q;
    assign pc        = pc_q;
    assign link_addr = pc_plus4;
    assign rf_we     = rf_we_d;
    assign state     = state_q;
    assign retired   = retired_q;
    assign halted    = (state_q == S_HALT);
    assign misalign  = misalign_q;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed bench for core_sequencer: run mode, fetch wait states, branch/jump targets,
// misaligned trap, halt/single-step and reset during a data access.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic        step_req;
    logic        halt_req;
    logic [31:0] instr;
    logic        needs_mem;
    logic        wb_en_dec;
    logic [1:0]  pc_jmp;
    logic        branch_taken;
    logic [31:0] imm;
    logic [31:0] jalr_target;
    logic [31:0] pc;
    logic [31:0] link_addr;
    logic        rf_we;
    logic [2:0]  state;
    logic [31:0] retired;
    logic        halted;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    core_sequencer_if #(.XLEN(32)) mem_if ();

    core_sequencer #(
        .XLEN(32),
        .RESET_VECTOR(32'h0),
        .CNT_W(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .step_req(step_req),
        .halt_req(halt_req),
        .mem(mem_if.master),
        .instr(instr),
        .needs_mem(needs_mem),
        .wb_en_dec(wb_en_dec),
        .pc_jmp(pc_jmp),
        .branch_taken(branch_taken),
        .imm(imm),
        .jalr_target(jalr_target),
        .pc(pc),
        .link_addr(link_addr),
        .rf_we(rf_we),
        .state(state),
        .retired(retired),
        .halted(halted),
        .misalign(misalign)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // From IDLE, launch one instruction in run mode and stop with the FSM in WRITEBACK.
    task automatic to_wb();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        tick();
        tick();
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; step_req = 1'b0; halt_req = 1'b0;
        needs_mem = 1'b0; wb_en_dec = 1'b0; pc_jmp = 2'd0; branch_taken = 1'b0;
        imm = '0; jalr_target = '0;
        mem_if.imem_ready = 1'b0; mem_if.imem_rdata = '0; mem_if.dmem_ready = 1'b0;
        tick();
        check("rst_state", state, 0);
        check("rst_pc", pc, 0);
        check("rst_instr", instr, 32'h13);
        check("rst_retired", retired, 0);
        check("rst_halted", halted, 0);
        check("rst_misalign", misalign, 0);
        check("rst_imem_req", mem_if.imem_req, 0);
        check("rst_dmem_req", mem_if.dmem_req, 0);
        check("rst_rf_we", rf_we, 0);

        // run mode, zero-wait fetch, three sequential addi
        reset = 1'b0; enable = 1'b1; wb_en_dec = 1'b1; pc_jmp = 2'd0;
        mem_if.imem_ready = 1'b1; mem_if.imem_rdata = 32'h0010_0093; mem_if.dmem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t1_fetch_state", state, 1);
            check("t1_fetch_addr", mem_if.imem_addr, 4 * i);
            check("t1_fetch_rfwe", rf_we, 0);
            tick();
            check("t1_dec_instr", instr, 32'h0010_0093);
            check("t1_dec_rfwe", rf_we, 0);
            tick();
            check("t1_exe_state", state, 3);
            check("t1_exe_rfwe", rf_we, 0);
            tick();
            check("t1_wb_state", state, 5);
            check("t1_wb_rfwe", rf_we, 1);
            check("t1_wb_pc", pc, 4 * i);
        end
        enable = 1'b0;
        tick();
        check("t1_idle_state", state, 0);
        check("t1_pc", pc, 12);
        check("t1_retired", retired, 3);

        // fetch with three wait cycles; garbage on rdata until ready
        mem_if.imem_ready = 1'b0; mem_if.imem_rdata = 32'hDEAD_0000; enable = 1'b1;
        tick();
        enable = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("t2_req", mem_if.imem_req, 1);
            check("t2_addr", mem_if.imem_addr, 12);
            check("t2_state", state, 1);
            check("t2_instr_hold", instr, 32'h0010_0093);
            if (k == 3) begin
                mem_if.imem_ready = 1'b1;
                mem_if.imem_rdata = 32'h0020_0113;
            end else begin
                mem_if.imem_rdata = 32'hDEAD_0001 + k;
            end
            tick();
        end
        check("t2_dec_state", state, 2);
        check("t2_dec_req", mem_if.imem_req, 0);
        check("t2_instr", instr, 32'h0020_0113);
        mem_if.imem_rdata = 32'hFFFF_FFFF;
        tick();
        check("t2_instr_once", instr, 32'h0020_0113);
        tick();
        tick();
        check("t2_pc", pc, 16);
        check("t2_retired", retired, 4);

        // branch / jump targets
        pc_jmp = 2'd1; branch_taken = 1'b1; imm = 32'hFFFF_FFF8; wb_en_dec = 1'b0;
        to_wb();
        check("t3_beq_wb_state", state, 5);
        check("t3_beq_rfwe", rf_we, 0);
        tick();
        check("t3_beq_taken_pc", pc, 8);

        pc_jmp = 2'd2; imm = 32'd8; wb_en_dec = 1'b1;
        to_wb();
        check("t3_jal_rfwe", rf_we, 1);
        check("t3_jal_link", link_addr, 12);
        tick();
        check("t3_jal_pc", pc, 16);

        pc_jmp = 2'd1; branch_taken = 1'b0; imm = 32'hFFFF_FFF8; wb_en_dec = 1'b0;
        to_wb();
        tick();
        check("t3_beq_nt_pc", pc, 20);

        pc_jmp = 2'd3; jalr_target = 32'h0000_0105; wb_en_dec = 1'b1;
        to_wb();
        check("t3_jalr_link", link_addr, 24);
        check("t3_jalr_rfwe", rf_we, 1);
        tick();
        check("t3_jalr_pc", pc, 32'h104);
        check("t3_jalr_retired", retired, 8);
        check("t3_jalr_misalign", misalign, 0);

        jalr_target = 32'hFFFF_FFFD;
        to_wb();
        tick();
        check("t3_jalr_top_pc", pc, 32'hFFFF_FFFC);
        pc_jmp = 2'd0;
        to_wb();
        check("t3_wrap_link", link_addr, 0);
        tick();
        check("t3_wrap_pc", pc, 0);
        check("t3_wrap_retired", retired, 10);

        // misaligned jal target traps
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_jmp = 2'd2; imm = 32'd6; wb_en_dec = 1'b1;
        to_wb();
        check("t4_wb_rfwe", rf_we, 0);
        tick();
        check("t4_state", state, 6);
        check("t4_halted", halted, 1);
        check("t4_misalign", misalign, 1);
        check("t4_pc", pc, 0);
        check("t4_retired", retired, 0);
        enable = 1'b1;
        tick();
        tick();
        check("t4_enable_ignored", state, 6);
        check("t4_misalign_sticky", misalign, 1);
        enable = 1'b0;

        // halt request mid-instruction, then single-step out of HALT
        reset = 1'b1;
        tick();
        reset = 1'b0;
        pc_jmp = 2'd0; wb_en_dec = 1'b1; enable = 1'b1;
        tick();
        tick();
        tick();
        check("t5_exe_state", state, 3);
        halt_req = 1'b1;
        tick();
        halt_req = 1'b0;
        check("t5_wb_state", state, 5);
        check("t5_wb_rfwe", rf_we, 1);
        tick();
        check("t5_halt_state", state, 6);
        check("t5_halted", halted, 1);
        check("t5_retired", retired, 1);
        check("t5_pc", pc, 4);
        check("t5_misalign", misalign, 0);
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("t5_step_fetch", state, 1);
        check("t5_step_halted", halted, 0);
        tick();
        step_req = 1'b1;
        tick();
        step_req = 1'b0;
        check("t5_step_exe", state, 3);
        tick();
        check("t5_step_rfwe", rf_we, 1);
        tick();
        check("t5_step_back_halt", state, 6);
        check("t5_step_retired", retired, 2);
        check("t5_step_pc", pc, 8);
        tick();
        check("t5_stays_halt", state, 6);
        enable = 1'b0;

        // reset while a data access is stalled
        reset = 1'b1;
        tick();
        reset = 1'b0;
        enable = 1'b1; needs_mem = 1'b1; mem_if.dmem_ready = 1'b1; wb_en_dec = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t6_mem_state", state, 4);
        check("t6_mem_req", mem_if.dmem_req, 1);
        tick();
        check("t6_wb_state", state, 5);
        tick();
        check("t6_pc", pc, 4);
        check("t6_retired", retired, 1);
        mem_if.dmem_ready = 1'b0;
        tick();
        tick();
        tick();
        tick();
        check("t6_stall_state", state, 4);
        check("t6_stall_req", mem_if.dmem_req, 1);
        reset = 1'b1;
        tick();
        check("t6_rst_state", state, 0);
        check("t6_rst_dmem_req", mem_if.dmem_req, 0);
        check("t6_rst_pc", pc, 0);
        check("t6_rst_retired", retired, 0);
        reset = 1'b0; enable = 1'b0; needs_mem = 1'b0;
        tick();
        check("t6_idle_after", state, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
